// File: rtl/inst_arb_pkg.sv
// Shared types and defaults for the sibling-instance round-robin arbiter.
package inst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF    = 15;
    localparam int HOLD_MAX_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request at or after ptr, wrapping to 0.
module rr_pick #(
    parameter int N    = 15,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] index,
    output logic            any
);

    int               j;
    logic [ID_W-1:0]  idx;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        j      = 0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = j[ID_W-1:0];
            if (!any && req[idx]) begin
                any   = 1'b1;
                index = idx;
            end
        end
        if (any) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter with hold-time watchdog for the generated leaf instances.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on any request
//   GRANT | one owner holds gnt; hold counter running toward HOLD_MAX-1
//   GAP   | one-cycle dead time after release; arbitrates like IDLE
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout
);

    localparam int CNT_W = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic             owner_release;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_id),
        .any    (pick_any)
    );

    // Masking with gnt ignores done/req bits of every non-owner.
    assign owner_release = (|(done & gnt)) || !(|(req & gnt));
    assign next_ptr      = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        gnt       <= pick_onehot;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_id;
                        cnt       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (owner_release || cnt == HOLD_LAST) begin
                        // Normal release takes precedence over the watchdog.
                        timeout   <= !owner_release;
                        state     <= GAP;
                        ptr       <= next_ptr;
                        cnt       <= '0;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    gnt_id    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Directed bench for inst_rr_arbiter with hand-computed expected grants.
module tb_inst_rr_arbiter;

    localparam int N = 15;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [3:0]    gnt_id;
    logic          timeout;

    int n_chk;
    int n_err;

    inst_rr_arbiter #(
        .N_REQ    (15),
        .HOLD_MAX (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input int id);
        check_val({tag, "_gnt"}, 32'(gnt), 32'(1) << id);
        check_val({tag, "_id"}, 32'(gnt_id), 32'(id));
        check_val({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_gnt"}, 32'(gnt), 32'd0);
        check_val({tag, "_id"}, 32'(gnt_id), 32'd0);
        check_val({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        req   = '0;
        done  = '0;

        // single requester, release by done
        do_reset();
        check_idle("rst");
        check_val("rst_timeout", 32'(timeout), 32'd0);
        req = 15'h0001;
        tick();
        check_grant("t1_grant", 0);
        done = 15'h0001;
        tick();
        check_idle("t1_gap");
        done = '0;
        req  = '0;
        tick();

        // full rotation with everyone requesting
        do_reset();
        req = 15'h7FFF;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_grant($sformatf("t2_grant%0d", k), k % N);
            tick();
            check_grant($sformatf("t2_hold%0d", k), k % N);
            done = '0;
            done[k % N] = 1'b1;
            tick();
            check_idle($sformatf("t2_gap%0d", k));
            done = '0;
        end
        req = '0;
        tick();

        // wrap from ptr 14 to a lower index
        do_reset();
        req = 15'h2000;
        tick();
        check_grant("t3_g13", 13);
        done = 15'h2000;
        tick();
        done = '0;
        req  = 15'h4004;
        tick();
        check_grant("t3_g14", 14);
        done = 15'h4000;
        tick();
        check_idle("t3_gap14");
        done = '0;
        tick();
        check_grant("t3_g2", 2);
        req = '0;
        tick();
        check_idle("t3_reqdrop");
        tick();

        // watchdog reclaims a stuck owner
        do_reset();
        req = 15'h0060;
        tick();
        check_grant("t4_g5", 5);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_val($sformatf("t4_hold%0d", i), 32'(gnt), 32'h20);
            check_val($sformatf("t4_to%0d", i), 32'(timeout), 32'd0);
        end
        tick();
        check_idle("t4_reclaim");
        check_val("t4_timeout", 32'(timeout), 32'd1);
        tick();
        check_grant("t4_g6", 6);
        check_val("t4_to_low", 32'(timeout), 32'd0);
        req = '0;
        tick();
        tick();

        // foreign done ignored; release coinciding with expiry wins
        do_reset();
        req = 15'h0080;
        tick();
        check_grant("t5_g7", 7);
        req = 15'h0088;
        for (int i = 1; i < 16; i++) begin
            done = (i % 3 == 1) ? 15'h0008 : 15'h0000;
            tick();
            check_val($sformatf("t5_hold%0d", i), 32'(gnt), 32'h80);
        end
        done = 15'h0080;
        tick();
        check_idle("t5_release");
        check_val("t5_no_timeout", 32'(timeout), 32'd0);
        done = '0;
        tick();
        check_grant("t5_g3", 3);
        req = '0;
        tick();
        tick();

        // asynchronous reset mid-grant
        do_reset();
        req = 15'h0200;
        tick();
        check_grant("t6_g9", 9);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        check_val("t6_timeout", 32'(timeout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 15'h0201;
        tick();
        check_grant("t6_g0", 0);
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
